gpio_debounced: RTL

Parametrised button/LED peripheral that replaces the fixed single-button, six-LED wiring at the top level with a memory-mapped block. It synchronises and debounces `BTN_COUNT` raw button pins, latches press events, drives `LED_WIDTH` LEDs from a register, and raises a level interrupt. It sits on the SoC's internal register bus next to the UART, and its pins go straight to board I/O.

---
 rtl/gpio_debounced.sv | 115 +++++++++++
 1 files changed

// File: rtl/gpio_debounced.sv
// Memory-mapped button/LED peripheral: per-button sync + debounce, press-event
// latching with write-1-to-clear, LED register, and a level interrupt.
module gpio_debounced #(
    parameter int unsigned CLK_FREQ        = 27_000_000,
    parameter int unsigned BTN_COUNT       = 1,
    parameter int unsigned LED_WIDTH       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 270_000,
    parameter int unsigned BTN_ACTIVE_LOW  = 0,
    parameter int unsigned LED_ACTIVE_LOW  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_COUNT-1:0] btn,
    output logic [LED_WIDTH-1:0] led,
    input  logic [3:0]           addr,
    input  logic                 we,
    input  logic [31:0]          wdata,
    input  logic                 re,
    output logic [31:0]          rdata,
    output logic                 irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BTN_COUNT-1:0] btn_in;
    logic [BTN_COUNT-1:0] sync_meta;
    logic [BTN_COUNT-1:0] sync;
    logic [BTN_COUNT-1:0] stable;
    logic [BTN_COUNT-1:0] rise;
    logic [BTN_COUNT-1:0] evt_reg;
    logic [BTN_COUNT-1:0] evt_clr;
    logic [BTN_COUNT-1:0] irq_en;
    logic [CNT_W-1:0]     cnt [BTN_COUNT];
    logic [LED_WIDTH-1:0] led_reg;
    logic [31:0]          rdata_next;
    logic                 unused_bits;

    assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn : btn;
    assign led    = (LED_ACTIVE_LOW != 0) ? ~led_reg : led_reg;
    assign irq    = |(evt_reg & irq_en);
    assign unused_bits = ^{addr[1:0], wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
        end
    end

    // A bit rises on exactly the edge where its debounce count completes.
    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < BTN_COUNT; i++) begin
            rise[i] = sync[i] & ~stable[i] & (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int unsigned i = 0; i < BTN_COUNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < BTN_COUNT; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign evt_clr = (we && addr[3:2] == 2'd2) ? wdata[BTN_COUNT-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg <= '0;
            irq_en  <= '0;
            evt_reg <= '0;
        end else begin
            if (we && addr[3:2] == 2'd0) led_reg <= wdata[LED_WIDTH-1:0];
            if (we && addr[3:2] == 2'd3) irq_en  <= wdata[BTN_COUNT-1:0];
            // New event wins over a coincident clear of the same bit.
            evt_reg <= (evt_reg & ~evt_clr) | rise;
        end
    end

    always_comb begin
        rdata_next = '0;
        case (addr[3:2])
            2'd0:    rdata_next[LED_WIDTH-1:0] = led_reg;
            2'd1:    rdata_next[BTN_COUNT-1:0] = stable;
            2'd2:    rdata_next[BTN_COUNT-1:0] = evt_reg;
            default: rdata_next[BTN_COUNT-1:0] = irq_en;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rdata_next;
        end
    end

endmodule
